// File: rtl/kfps2kb_pkg.sv
// Shared types and sizing for the PS/2 keyboard receive controller.
package kfps2kb_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    DISABLED,
    RUN,
    INHIBIT_ERR,
    INHIBIT_FULL
  } kb_state_t;

endpackage

// File: rtl/ps2kb_scancode_fifo.sv
// Four-entry scancode buffer with push/pop/flush, occupancy count and a
// one-cycle overrun pulse when a byte arrives while full without a pop.
module ps2kb_scancode_fifo
  import kfps2kb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overrun
);

  logic [7:0]            mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  overrun_reg;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;
  logic [FIFO_DEPTH-1:0] wr_en;

  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full buffer still accepts a byte when the head is popped in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && !do_push;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      overrun_reg <= drop;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
      end
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/ps2kb_rx_controller.sv
// PS/2 keyboard receive controller: scancode buffer, irq, clock-line inhibit FSM.
// Define KFPS2KB_ERROR_COUNT_EN to add the saturating error_count output.
module ps2kb_rx_controller
  import kfps2kb_pkg::*;
#(
  parameter logic [15:0] inhibit_time = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       peripheral_clock,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic       read_ack,
  input  logic       flush,
  output logic [7:0] keycode,
  output logic       irq,
  output logic       device_clock_inhibit,
  output logic [2:0] fifo_count,
  output logic       overrun
`ifdef KFPS2KB_ERROR_COUNT_EN
  ,
  output logic [7:0] error_count
`endif
);

  kb_state_t   state_reg;
  logic [15:0] timer_reg;
  logic        inhibit_reg;
  logic        pclk_meta_reg;
  logic        pclk_sync_reg;
  logic        pclk_prev_reg;
  logic        tick;
  logic        fifo_full;

  ps2kb_scancode_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (read_ack),
    .flush     (flush),
    .head_data (keycode),
    .count     (fifo_count),
    .full      (fifo_full),
    .overrun   (overrun)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pclk_meta_reg <= 1'b0;
      pclk_sync_reg <= 1'b0;
      pclk_prev_reg <= 1'b0;
    end else begin
      pclk_meta_reg <= peripheral_clock;
      pclk_sync_reg <= pclk_meta_reg;
      pclk_prev_reg <= pclk_sync_reg;
    end
  end

  assign tick = pclk_sync_reg && !pclk_prev_reg;

  // Inhibit is registered alongside the state so it is low exactly while in RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= DISABLED;
      timer_reg   <= '0;
      inhibit_reg <= 1'b1;
    end else if (!enable) begin
      state_reg   <= DISABLED;
      inhibit_reg <= 1'b1;
    end else begin
      case (state_reg)
        DISABLED: begin
          state_reg   <= RUN;
          inhibit_reg <= 1'b0;
        end
        RUN: begin
          if (rx_error) begin
            state_reg   <= INHIBIT_ERR;
            timer_reg   <= '0;
            inhibit_reg <= 1'b1;
          end else if (fifo_full) begin
            state_reg   <= INHIBIT_FULL;
            inhibit_reg <= 1'b1;
          end
        end
        INHIBIT_ERR: begin
          if (timer_reg >= inhibit_time) begin
            if (fifo_full) begin
              state_reg   <= INHIBIT_FULL;
              inhibit_reg <= 1'b1;
            end else begin
              state_reg   <= RUN;
              inhibit_reg <= 1'b0;
            end
          end else if (tick) begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        INHIBIT_FULL: begin
          if (!fifo_full) begin
            state_reg   <= RUN;
            inhibit_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= DISABLED;
          inhibit_reg <= 1'b1;
        end
      endcase
    end
  end

  assign device_clock_inhibit = inhibit_reg;
  assign irq                  = enable && (fifo_count != '0);

`ifdef KFPS2KB_ERROR_COUNT_EN
  logic [7:0] error_count_reg;
  logic       drop_event;

  assign drop_event = rx_valid && fifo_full && !read_ack && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count_reg <= '0;
    end else if (flush) begin
      error_count_reg <= '0;
    end else if ((rx_error || drop_event) && (error_count_reg != 8'hFF)) begin
      error_count_reg <= error_count_reg + 8'd1;
    end
  end

  assign error_count = error_count_reg;
`endif

endmodule

// File: tb/tb_ps2kb_rx_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_ps2kb_rx_controller;

  localparam int IT     = 5;
  localparam int M_DIS  = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;
  localparam int M_FULL = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       peripheral_clock;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       read_ack;
  logic       flush;
  logic [7:0] keycode;
  logic       irq;
  logic       device_clock_inhibit;
  logic [2:0] fifo_count;
  logic       overrun;
`ifdef KFPS2KB_ERROR_COUNT_EN
  logic [7:0] error_count;
`endif

  int checks = 0;
  int errors = 0;
  bit pc_random = 1'b0;

  always #5 clock = ~clock;

  ps2kb_rx_controller #(.inhibit_time(16'd5)) dut (
    .clock                (clock),
    .reset                (reset),
    .peripheral_clock     (peripheral_clock),
    .enable               (enable),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_error             (rx_error),
    .read_ack             (read_ack),
    .flush                (flush),
    .keycode              (keycode),
    .irq                  (irq),
    .device_clock_inhibit (device_clock_inhibit),
    .fifo_count           (fifo_count),
    .overrun              (overrun)
`ifdef KFPS2KB_ERROR_COUNT_EN
    ,
    .error_count          (error_count)
`endif
  );

  // ---------------- reference model ----------------
  byte unsigned mq[$];
  bit           pc_seen[$];
  int           m_mode;
  int           m_ticks_left;
  bit           m_ovr;
  int           m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pc_seen = '{1'b0, 1'b0, 1'b0};
    m_mode = M_DIS;
    m_ticks_left = 0;
    m_ovr = 1'b0;
    m_err = 0;
  endtask

  task automatic model_step();
    bit full_now;
    bit tick;
    bit drop;
    full_now = (mq.size() == 4);
    // A rising edge between the samples taken 3 and 2 clocks ago is seen now.
    tick = pc_seen[1] && !pc_seen[2];
    pc_seen.push_front(peripheral_clock);
    void'(pc_seen.pop_back());

    if (!enable) begin
      m_mode = M_DIS;
    end else if (m_mode == M_DIS) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (rx_error) begin
        m_mode = M_ERR;
        m_ticks_left = IT;
      end else if (full_now) begin
        m_mode = M_FULL;
      end
    end else if (m_mode == M_ERR) begin
      if (m_ticks_left == 0) m_mode = full_now ? M_FULL : M_RUN;
      else if (tick) m_ticks_left--;
    end else if (m_mode == M_FULL) begin
      if (!full_now) m_mode = M_RUN;
    end

    drop = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (read_ack && mq.size() > 0) void'(mq.pop_front());
      if (rx_valid) begin
        if (mq.size() < 4) mq.push_back(rx_data);
        else drop = 1'b1;
      end
    end
    m_ovr = drop;
    if (flush) m_err = 0;
    else if ((rx_error || drop) && m_err < 255) m_err++;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    check("irq", irq, int'(mq.size() != 0 && enable));
    check("inhibit", device_clock_inhibit, int'(m_mode != M_RUN));
    check("fifo_count", fifo_count, mq.size());
    check("overrun", overrun, m_ovr);
    if (mq.size() > 0) check("keycode", keycode, mq[0]);
`ifdef KFPS2KB_ERROR_COUNT_EN
    check("error_count", error_count, m_err);
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n = 0;
    peripheral_clock = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (pc_random) begin
        if ($urandom_range(3) == 0) peripheral_clock = ~peripheral_clock;
      end else begin
        n++;
        if (n == 3) begin
          n = 0;
          peripheral_clock = ~peripheral_clock;
        end
      end
    end
  end

  task automatic step(input bit v, input byte unsigned d, input bit e, input bit a, input bit f);
    rx_valid = v;
    rx_data  = d;
    rx_error = e;
    read_ack = a;
    flush    = f;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    read_ack = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    enable = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    read_ack = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_inhibit", device_clock_inhibit, 1);
    check("rst_count", fifo_count, 0);
    check("rst_irq", irq, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    idle(1);
    check("dis_inhibit", device_clock_inhibit, 1);

    enable = 1'b1;
    idle(1);
    $display("txn enable: inhibit=%0d irq=%0d count=%0d", device_clock_inhibit, irq, fifo_count);
    check("en_inhibit", device_clock_inhibit, 0);
    check("en_irq", irq, 0);
    check("en_count", fifo_count, 0);

    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    $display("txn push 1C,F0: count=%0d keycode=%02h", fifo_count, keycode);
    check("two_count", fifo_count, 2);
    check("two_keycode", keycode, 8'h1C);
    check("two_irq", irq, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    $display("txn ack: keycode=%02h", keycode);
    check("ack_keycode", keycode, 8'hF0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ack_empty", fifo_count, 0);

    for (int i = 0; i < 4; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("full_count", fifo_count, 4);
    idle(1);
    $display("txn fill: count=%0d inhibit=%0d", fifo_count, device_clock_inhibit);
    check("full_inhibit", device_clock_inhibit, 1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    $display("txn overrun push: overrun=%0d count=%0d", overrun, fifo_count);
    check("ovr_pulse", overrun, 1);
    check("ovr_count", fifo_count, 4);
    check("ovr_keycode", keycode, 8'hA1);
    idle(1);
    check("ovr_once", overrun, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pop_count", fifo_count, 3);
    check("pop_inh_still", device_clock_inhibit, 1);
    idle(1);
    check("pop_inh_low", device_clock_inhibit, 0);

    step(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'hC6, 1'b0, 1'b1, 1'b0);
    $display("txn full push+pop: count=%0d overrun=%0d keycode=%02h", fifo_count, overrun, keycode);
    check("pp_count", fifo_count, 4);
    check("pp_overrun", overrun, 0);
    check("pp_keycode", keycode, 8'hA3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pp_stored", keycode, 8'hC6);
    check("pp_left", fifo_count, 1);
    step(1'b1, 8'hD7, 1'b0, 1'b0, 1'b1);
    $display("txn flush+push: count=%0d", fifo_count);
    check("flush_count", fifo_count, 0);
    idle(2);

    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("err_inhibit", device_clock_inhibit, 1);
    idle(15);
    check("err_hold", device_clock_inhibit, 1);
    idle(60);
    $display("txn error recovery: inhibit=%0d", device_clock_inhibit);
    check("err_release", device_clock_inhibit, 0);
`ifdef KFPS2KB_ERROR_COUNT_EN
    check("err_count", error_count, 1);
`endif

    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("dis_err_inh", device_clock_inhibit, 1);
    enable = 1'b0;
    idle(1);
    $display("txn disable in error: irq=%0d count=%0d", irq, fifo_count);
    check("dis_irq", irq, 0);
    check("dis_count", fifo_count, 2);
    check("dis_inh", device_clock_inhibit, 1);
    enable = 1'b1;
    idle(1);
    $display("txn re-enable: inhibit=%0d irq=%0d keycode=%02h", device_clock_inhibit, irq, keycode);
    check("reen_inh", device_clock_inhibit, 0);
    check("reen_irq", irq, 1);
    check("reen_keycode", keycode, 8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    pc_random = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit v, e, a, f;
      if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end
      if (enable) begin
        if ($urandom_range(99) == 0) enable = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        enable = 1'b1;
      end
      v = ($urandom_range(99) < 45);
      a = ($urandom_range(99) < 35);
      e = ($urandom_range(99) < 2);
      f = ($urandom_range(99) < 2);
      step(v, 8'($urandom_range(255)), e, a, f);
    end
    $display("txn random traffic: 3000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2kb_rx_controller.md
PS2KB_RX_CONTROLLER -- requirements
Module: ps2kb_rx_controller

Interface
REQ-001 Parameter inhibit_time, default 16'd1000: minimum error-recovery inhibit length, in peripheral_clock rising edges.
REQ-002 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port peripheral_clock, input, 1: slow timebase; edge-detected internally.
REQ-005 Port enable, input, 1: host enable for keyboard reception.
REQ-006 Port rx_data, input, 8: byte from the PS/2 shift register.
REQ-007 Port rx_valid, input, 1: one-cycle pulse; rx_data is good.
REQ-008 Port rx_error, input, 1: one-cycle pulse; framing, parity or timeout error.
REQ-009 Port read_ack, input, 1: one-cycle pulse; host has consumed keycode.
REQ-010 Port flush, input, 1: one-cycle pulse; discard all buffered bytes.
REQ-011 Port keycode, output, 8: FIFO head byte.
REQ-012 Port irq, output, 1: level; high when the FIFO is non-empty and enable=1.
REQ-013 Port device_clock_inhibit, output, 1: 1 means drive the PS/2 clock line low.
REQ-014 Port fifo_count, output, 3: number of buffered bytes, 0 to 4.
REQ-015 Port overrun, output, 1: one-cycle pulse; a byte was dropped.

Function
REQ-016 FIFO depth: 4 bytes; 2-bit read/write pointers wrap 3->0; fifo_count is 3 bits.
REQ-017 Push: rx_valid=1 and FIFO not full stores rx_data; keycode, irq and fifo_count reflect it on the next cycle.
REQ-018 rx_valid=1 while full: byte dropped; overrun=1 for exactly one cycle; FIFO unchanged.
REQ-019 Pop: read_ack=1 while non-empty advances the read pointer; read_ack while empty is ignored.
REQ-020 Simultaneous push and pop: both performed; fifo_count unchanged, including when full; no overrun.
REQ-021 flush: empties the FIFO and overrides any push or pop in the same cycle.
REQ-022 Pushes are accepted in every state, including while inhibiting, if the FIFO has room.
REQ-023 keycode = memory[read pointer]; its value when the FIFO is empty is don't-care.
REQ-024 peripheral_clock: two-flop synchronizer; one tick per rising edge.
REQ-025 FSM states: DISABLED, RUN, INHIBIT_ERR, INHIBIT_FULL; device_clock_inhibit=0 only in RUN.
REQ-026 DISABLED -> RUN when enable=1.
REQ-027 RUN -> INHIBIT_ERR on rx_error; clears the 16-bit timer.
REQ-028 RUN -> INHIBIT_FULL when fifo_count reaches 4; rx_error takes priority over full.
REQ-029 INHIBIT_ERR: timer increments on each tick and saturates at inhibit_time; at timer >= inhibit_time the next state is INHIBIT_FULL if full, else RUN.
REQ-030 INHIBIT_FULL -> RUN in the cycle after fifo_count < 4 (pop or flush).
REQ-031 enable=0 forces DISABLED from any state, highest priority; FIFO contents are retained; irq is masked.
REQ-032 rx_error received outside RUN does not restart the timer.

Reset
REQ-033 Reset values: state=DISABLED, pointers=0, fifo_count=0, timer=0, irq=0, overrun=0, device_clock_inhibit=1, synchronizer flops=0.
REQ-034 Reset asserted mid-operation discards all buffered data; no overrun pulse is generated.

Configuration
REQ-035 Macro KFPS2KB_ERROR_COUNT_EN defined: adds output error_count[7:0], which increments on each rx_error or overrun event, saturates at 8'hFF, clears on reset or flush, and counts once when both events occur in the same cycle.
REQ-036 Macro undefined: the error_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Package kfps2kb_pkg holds the FSM state enum and the FIFO depth constant (4).
REQ-038 Sub-module ps2kb_scancode_fifo implements the buffer, push/pop/flush and count; the FSM and timer stay in the top level.

Verification
REQ-039 Reset, then enable=1 -> device_clock_inhibit goes 1->0 on the next cycle; irq=0; fifo_count=0.
REQ-040 Push 8'h1C, then 8'hF0 -> fifo_count=2, keycode=8'h1C, irq=1; after read_ack, keycode=8'hF0.
REQ-041 Push 4 bytes -> INHIBIT_FULL with inhibit=1; fifth rx_valid -> overrun pulse, count stays 4; read_ack -> inhibit=0 the cycle after.
REQ-042 rx_error in RUN with inhibit_time=16'd5 -> inhibit high for 5 ticks, then low; error_count=1 when the macro is defined.
REQ-043 Full FIFO with same-cycle rx_valid and read_ack -> count stays 4, new byte stored, no overrun; flush+rx_valid same cycle -> count=0.
REQ-044 enable=0 during INHIBIT_ERR -> DISABLED immediately, irq=0, FIFO retained; re-enable -> RUN with contents intact.
